// File: rtl/baud_ctrl.sv
// Oversampling baud tick generator with manual divisor and autobaud measurement of one low bit on rx.
// o_tick decodes registered state; a new divisor applies at the next counter wrap; no backpressure.
module baud_ctrl #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEFAULT_BAUD = 19200,
    parameter int OVERSAMPLING = 16,
    parameter int NB_DIV       = 16
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_rx,
    input  logic              i_div_wr,
    input  logic [NB_DIV-1:0] i_div,
    input  logic              i_autobaud_start,
    output logic              o_tick,
    output logic [NB_DIV-1:0] o_div,
    output logic              o_busy,
    output logic              o_locked,
    output logic              o_err
);
    localparam int LOG_OS = $clog2(OVERSAMPLING);
    localparam int NB_L   = NB_DIV + LOG_OS;
    localparam logic [NB_DIV-1:0] DEF_DIV = NB_DIV'(CLK_FREQ / (DEFAULT_BAUD * OVERSAMPLING) - 1);
    localparam logic [NB_L-1:0]   L_MIN   = NB_L'(2 * OVERSAMPLING);
    localparam logic [NB_L-1:0]   L_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_WAIT_FALL,
        ST_MEASURE,
        ST_UPDATE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NB_DIV-1:0] cnt;
    logic [NB_DIV-1:0] div_q;
    logic [NB_DIV-1:0] pend_q;
    logic [NB_L-1:0]   l_cnt;
    logic              rx_m;
    logic              rx_s;
    logic              rx_d;
    logic              rx_fall;
    logic              rx_rise;
    logic              l_sat;
    logic              div_load;
    logic              ab_clear;
    logic              ab_fail;
    logic              ab_ok;

    // Counter never exceeds div_q in normal operation; >= keeps it safe if that ever changes.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt   <= '0;
            div_q <= DEF_DIV;
        end else if (cnt >= div_q) begin
            cnt   <= '0;
            div_q <= pend_q;
        end else begin
            cnt <= cnt + NB_DIV'(1);
        end
    end

    assign o_tick   = (cnt == div_q);
    assign o_div    = div_q;
    assign div_load = i_div_wr && !o_busy;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q   <= DEF_DIV;
            o_locked <= 1'b0;
        end else begin
            if (div_load) begin
                pend_q <= (i_div == '0) ? NB_DIV'(1) : i_div;
            end else if (ab_ok) begin
                pend_q <= l_cnt[NB_L-1:LOG_OS] - NB_DIV'(1);
            end
            if (ab_clear || div_load) begin
                o_locked <= 1'b0;
            end else if (ab_ok) begin
                o_locked <= 1'b1;
            end
        end
    end

    // Line idles high, so the synchronizer and edge history reset to 1.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign rx_fall = rx_d && !rx_s;
    assign rx_rise = !rx_d && rx_s;
    assign l_sat   = (l_cnt == L_MAX);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (i_autobaud_start) state_nxt = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (rx_s) state_nxt = ST_WAIT_FALL;
            ST_WAIT_FALL: if (rx_fall) state_nxt = ST_MEASURE;
            ST_MEASURE: begin
                if (rx_rise) begin
                    state_nxt = ST_UPDATE;
                end else if (!rx_s && l_sat) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_UPDATE:    state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state != ST_IDLE);
        ab_clear = 1'b0;
        ab_fail  = 1'b0;
        ab_ok    = 1'b0;
        case (state)
            ST_IDLE:    ab_clear = i_autobaud_start;
            ST_MEASURE: ab_fail  = !rx_s && l_sat;
            ST_UPDATE: begin
                if (l_cnt < L_MIN) begin
                    ab_fail = 1'b1;
                end else begin
                    ab_ok = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The falling-edge cycle itself is the first low cycle of the bit.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            l_cnt <= '0;
            o_err <= 1'b0;
        end else begin
            if (state == ST_WAIT_FALL && rx_fall) begin
                l_cnt <= NB_L'(1);
            end else if (state == ST_MEASURE && !rx_s && !l_sat) begin
                l_cnt <= l_cnt + NB_L'(1);
            end
            if (ab_clear) begin
                o_err <= 1'b0;
            end else if (ab_fail) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_baud_ctrl.sv
// Bench for baud_ctrl: tick-schedule reference model checked every cycle, a divisor/period table,
// directed autobaud and reset sequences, then randomized writes and autobaud pulses.
module tb_baud_ctrl;
    localparam int NB_DIV  = 16;
    localparam int OS      = 16;
    localparam int DEF_DIV = 50_000_000 / (19200 * OS) - 1;

    logic              clk;
    logic              i_rst_n;
    logic              i_rx;
    logic              i_div_wr;
    logic [NB_DIV-1:0] i_div;
    logic              i_autobaud_start;
    logic              o_tick;
    logic [NB_DIV-1:0] o_div;
    logic              o_busy;
    logic              o_locked;
    logic              o_err;

    baud_ctrl #(
        .CLK_FREQ    (50_000_000),
        .DEFAULT_BAUD(19200),
        .OVERSAMPLING(OS),
        .NB_DIV      (NB_DIV)
    ) dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .i_rx            (i_rx),
        .i_div_wr        (i_div_wr),
        .i_div           (i_div),
        .i_autobaud_start(i_autobaud_start),
        .o_tick          (o_tick),
        .o_div           (o_div),
        .o_busy          (o_busy),
        .o_locked        (o_locked),
        .o_err           (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the schedule of ticks plus the divisor values in force.
    int cyc      = 0;
    int m_nxt    = -1;
    int m_cur    = DEF_DIV;
    int m_pend   = DEF_DIV;
    bit m_busy   = 1'b0;
    bit m_locked = 1'b0;
    bit m_err    = 1'b0;
    int ab_at    = -1;
    int ab_len   = 0;
    bit seen_tick;
    int seen_cyc;

    typedef struct {
        logic [NB_DIV-1:0] div_in;
        int                exp_div;
        int                exp_per;
    } vec_t;
    vec_t tbl[7];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // One clock: check this cycle's outputs, then drive inputs for the next edge and advance the model.
    task automatic step(input logic rx, input logic wr, input logic [NB_DIV-1:0] dv, input logic start);
        @(negedge clk);
        cmp("tick", o_tick, (cyc == m_nxt));
        cmp("div", o_div, m_cur);
        cmp("busy", o_busy, m_busy);
        cmp("locked", o_locked, m_locked);
        cmp("err", o_err, m_err);
        seen_tick = o_tick;
        seen_cyc  = cyc;
        i_rx = rx;
        i_div_wr = wr;
        i_div = dv;
        i_autobaud_start = start;
        if (cyc == m_nxt) begin
            m_cur = m_pend;
            m_nxt = cyc + 1 + m_pend;
        end
        if (wr && !m_busy) begin
            m_pend   = (dv == '0) ? 1 : int'(dv);
            m_locked = 1'b0;
        end
        if (start && !m_busy) begin
            m_busy   = 1'b1;
            m_err    = 1'b0;
            m_locked = 1'b0;
        end
        if (cyc == ab_at) begin
            m_busy = 1'b0;
            ab_at  = -1;
            if (ab_len >= 2 * OS) begin
                m_pend   = ab_len / OS - 1;
                m_locked = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        i_rx = 1'b1;
        i_div_wr = 1'b0;
        i_autobaud_start = 1'b0;
        #1 i_rst_n = 1'b0;
        #1;
        cmp("rst_tick", o_tick, 0);
        cmp("rst_div", o_div, DEF_DIV);
        cmp("rst_busy", o_busy, 0);
        cmp("rst_locked", o_locked, 0);
        cmp("rst_err", o_err, 0);
        #1 i_rst_n = 1'b1;
        m_cur = DEF_DIV;
        m_pend = DEF_DIV;
        m_nxt = cyc + DEF_DIV;
        m_busy = 1'b0;
        m_locked = 1'b0;
        m_err = 1'b0;
        ab_at = -1;
        cyc++;
    endtask

    task automatic next_tick(output int at);
        at = -1;
        for (int k = 0; k < 1000 && at < 0; k++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (seen_tick) at = seen_cyc;
        end
    endtask

    task automatic tick_period(output int per);
        int t1;
        int t2;
        next_tick(t1);
        next_tick(t2);
        per = t2 - t1;
    endtask

    task automatic wait_div(input int target);
        for (int k = 0; k < 400 && int'(o_div) != target; k++) step(1'b1, 1'b0, '0, 1'b0);
        cmp("div_reached", o_div, target);
    endtask

    // Autobaud request followed by a low pulse of n cycles on the raw line; optional ignored noise.
    task automatic autobaud(input int n, input bit noise);
        step(1'b1, 1'b0, '0, 1'b1);
        idle(2);
        for (int k = 0; k < n; k++) begin
            logic w;
            logic s;
            w = noise && ($urandom_range(0, 15) == 0);
            s = noise && ($urandom_range(0, 15) == 0);
            step(1'b0, w, NB_DIV'($urandom_range(0, 60)), s);
        end
        ab_len = n;
        ab_at  = cyc + 3;
        step(1'b1, 1'b0, '0, 1'b0);
        idle(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int t;
        int t2;
        int per;
        tbl[0] = '{16'd9,   9,   10};
        tbl[1] = '{16'd0,   1,   2};
        tbl[2] = '{16'd2,   2,   3};
        tbl[3] = '{16'd1,   1,   2};
        tbl[4] = '{16'd26,  26,  27};
        tbl[5] = '{16'd100, 100, 101};
        tbl[6] = '{16'd5,   5,   6};

        i_rst_n = 1'b0;
        i_rx = 1'b1;
        i_div_wr = 1'b0;
        i_div = '0;
        i_autobaud_start = 1'b0;
        repeat (3) @(negedge clk);

        // Defaults out of reset: first tick 161 cycles after release, then period 162.
        r = cyc;
        reset_pulse();
        next_tick(t);
        cmp("first_tick_delay", t - r, 161);
        tick_period(per);
        cmp("default_period", per, 162);

        // Write at counter 50: the running period still ends at 161, then period 10.
        r = cyc;
        reset_pulse();
        idle(49);
        step(1'b1, 1'b1, 16'd9, 1'b0);
        next_tick(t);
        cmp("old_period_completes", t - r, 161);
        next_tick(t2);
        cmp("new_period_10", t2 - t, 10);

        foreach (tbl[v]) begin
            step(1'b1, 1'b1, tbl[v].div_in, 1'b0);
            wait_div(tbl[v].exp_div);
            tick_period(per);
            cmp("table_period", per, tbl[v].exp_per);
        end

        // 434-cycle bit -> divisor 26.
        reset_pulse();
        autobaud(434, 1'b0);
        cmp("ab434_locked", o_locked, 1);
        cmp("ab434_busy", o_busy, 0);
        cmp("ab434_err", o_err, 0);
        wait_div(26);
        tick_period(per);
        cmp("ab434_period", per, 27);

        // Too-short bit: error, divisor untouched.
        reset_pulse();
        autobaud(20, 1'b0);
        cmp("ab20_err", o_err, 1);
        cmp("ab20_locked", o_locked, 0);
        idle(200);
        cmp("ab20_div", o_div, DEF_DIV);

        // Threshold: 31 fails, 32 gives the minimum divisor.
        autobaud(31, 1'b0);
        cmp("ab31_err", o_err, 1);
        autobaud(32, 1'b0);
        cmp("ab32_err", o_err, 0);
        cmp("ab32_locked", o_locked, 1);
        wait_div(1);
        tick_period(per);
        cmp("ab32_period", per, 2);

        // Writes and restarts during measurement are ignored; the measurement wins.
        autobaud(600, 1'b1);
        cmp("ab600_locked", o_locked, 1);
        wait_div(36);
        tick_period(per);
        cmp("ab600_period", per, 37);

        // Reset in the middle of a measurement abandons it.
        step(1'b1, 1'b0, '0, 1'b1);
        idle(2);
        for (int k = 0; k < 100; k++) step(1'b0, 1'b0, '0, 1'b0);
        r = cyc;
        reset_pulse();
        next_tick(t);
        cmp("rst_mid_tick_delay", t - r, 161);
        cmp("rst_mid_locked", o_locked, 0);
        cmp("rst_mid_busy", o_busy, 0);

        for (int e = 0; e < 30; e++) begin
            int kind;
            kind = $urandom_range(0, 3);
            idle($urandom_range(0, 200));
            case (kind)
                0: step(1'b1, 1'b1, NB_DIV'($urandom_range(0, 60)), 1'b0);
                1: autobaud($urandom_range(2, 900), 1'b1);
                2: autobaud($urandom_range(2, 40), 1'b0);
                default: step(1'b1, 1'b1, '0, 1'b0);
            endcase
        end
        idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
